// File: rtl/seq_pkg.sv
// Shared types for the command sequencer: opcodes, the queued command word
// and the issue FSM states.
package seq_pkg;

  localparam int CMD_DATA_W = 8;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    LDA  = 2'd1,
    LDB  = 2'd2,
    EXEC = 2'd3
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [CMD_DATA_W-1:0] data;
    logic [2:0]            f;
    logic [1:0]            r;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic cmd_t pack_cmd(input logic [1:0]            op,
                                    input logic [CMD_DATA_W-1:0] data,
                                    input logic [2:0]            f,
                                    input logic [1:0]            r);
    cmd_t c;
    c.op   = op_e'(op);
    c.data = data;
    c.f    = f;
    c.r    = r;
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of command words with flush; DEPTH must be a power of two
// so the pointers wrap naturally.
module cmd_fifo
  import seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  cmd_t                         wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output cmd_t                         rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_q];
  assign do_push_s = push_i && !full_o && !flush_i;
  assign do_pop_s  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push_s) wr_q <= wr_q + PW'(1);
      if (do_pop_s)  rd_q <= rd_q + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Command-queue controller: buffers LDA/LDB/EXEC/NOP commands and issues them
// one at a time to the register unit as Ld_A/Ld_B/Shift_En strobes.
module cmd_sequencer
  import seq_pkg::*;
#(
  parameter int WIDTH = CMD_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  input  logic [2:0]                 cmd_f,
  input  logic [1:0]                 cmd_r,
  input  logic                       abort,
  output logic                       Ld_A,
  output logic                       Ld_B,
  output logic                       Shift_En,
  output logic [WIDTH-1:0]           D,
  output logic [2:0]                 F_S,
  output logic [1:0]                 R_S,
  output logic                       done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  op_e              cur_op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] d_q;
  logic [2:0]       f_q;
  logic [1:0]       r_q;

  cmd_t head_s;
  cmd_t wdata_s;
  logic fifo_full_s;
  logic fifo_empty_s;
  logic push_s;
  logic pop_s;

  assign cmd_ready = !fifo_full_s && !abort;
  assign push_s    = cmd_valid && cmd_ready;
  assign pop_s     = (state_q == IDLE) && !fifo_empty_s && !abort;
  assign wdata_s   = pack_cmd(cmd_op, cmd_data, cmd_f, cmd_r);

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (push_s),
    .wdata_i (wdata_s),
    .pop_i   (pop_s),
    .flush_i (abort),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count)
  );

  // Issue FSM; abort drops the current command without a done pulse but
  // leaves D/F_S/R_S as they were.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cur_op_q <= NOP;
      cnt_q    <= '0;
      d_q      <= '0;
      f_q      <= '0;
      r_q      <= '0;
    end else if (abort) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_s) begin
            cur_op_q <= head_s.op;
            d_q      <= head_s.data;
            cnt_q    <= '0;
            case (head_s.op)
              LDA, LDB: state_q <= LOAD;
              EXEC: begin
                state_q <= SHIFT;
                f_q     <= head_s.f;
                r_q     <= head_s.r;
              end
              default: state_q <= DONE;
            endcase
          end
        end
        LOAD:  state_q <= DONE;
        SHIFT: begin
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_q <= DONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are decoded straight from registers so reset removes them at once.
  assign Ld_A     = (state_q == LOAD) && (cur_op_q == LDA);
  assign Ld_B     = (state_q == LOAD) && (cur_op_q == LDB);
  assign Shift_En = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE) || !fifo_empty_s;
  assign D        = d_q;
  assign F_S      = f_q;
  assign R_S      = r_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: a queue-and-schedule reference model
// predicts strobes, queue occupancy and held selects every cycle.
module tb_cmd_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [2:0] cmd_f;
  logic [1:0] cmd_r;
  logic       abort;
  logic       Ld_A, Ld_B, Shift_En, done, busy;
  logic [7:0] D;
  logic [2:0] F_S;
  logic [1:0] R_S;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_f(cmd_f), .cmd_r(cmd_r),
    .abort(abort), .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En), .D(D),
    .F_S(F_S), .R_S(R_S), .done(done), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 Clk = ~Clk;

  // Reference model: queued commands plus a per-cycle schedule of strobes
  // {Ld_A, Ld_B, Shift_En, done} for the command in flight.
  typedef struct { logic [1:0] op; logic [7:0] d; logic [2:0] f; logic [1:0] r; } mcmd_t;
  mcmd_t      mq[$];
  logic [3:0] sched[$];
  logic [7:0] m_d;
  logic [2:0] m_f;
  logic [1:0] m_r;
  bit         m_pushed;

  function automatic logic [21:0] obs_vec();
    return {Ld_A, Ld_B, Shift_En, done, busy, cmd_ready, fifo_count, D, F_S, R_S};
  endfunction

  function automatic logic [21:0] exp_vec();
    logic [3:0] st;
    logic       bz;
    logic       rdy;
    st  = (sched.size() > 0) ? sched[0] : 4'b0000;
    bz  = (sched.size() > 0) || (mq.size() > 0);
    rdy = (mq.size() < DEPTH) && !abort;
    return {st, bz, rdy, 3'(mq.size()), m_d, m_f, m_r};
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] d,
                       input logic [2:0] f, input logic [1:0] r);
    cmd_valid = v; cmd_op = op; cmd_data = d; cmd_f = f; cmd_r = r;
  endtask

  task automatic tick();
    bit    acc;
    mcmd_t c;
    @(posedge Clk);
    acc      = cmd_valid && (mq.size() < DEPTH) && !abort;
    m_pushed = 1'b0;
    if (abort) begin
      mq.delete();
      sched.delete();
    end else begin
      if (sched.size() > 0) begin
        void'(sched.pop_front());
      end else if (mq.size() > 0) begin
        c   = mq.pop_front();
        m_d = c.d;
        case (c.op)
          2'd1: begin sched.push_back(4'b1000); sched.push_back(4'b0001); end
          2'd2: begin sched.push_back(4'b0100); sched.push_back(4'b0001); end
          2'd3: begin
            for (int i = 0; i < WIDTH; i++) sched.push_back(4'b0010);
            sched.push_back(4'b0001);
            m_f = c.f;
            m_r = c.r;
          end
          default: sched.push_back(4'b0001);
        endcase
      end
      if (acc) begin
        c.op = cmd_op; c.d = cmd_data; c.f = cmd_f; c.r = cmd_r;
        mq.push_back(c);
        m_pushed = 1'b1;
      end
    end
    #2;
  endtask

  task automatic model_reset();
    mq.delete();
    sched.delete();
    m_d = 8'h00; m_f = 3'd0; m_r = 2'd0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    abort   = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 3'd0, 2'd0);
    model_reset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
    end
    checks++;
    if (cmd_ready !== 1'b1 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL reset_ready: got ready=%b count=%0d want ready=1 count=0", cmd_ready, fifo_count);
    end
  endtask

  task automatic test_lda();
    int nld = 0, nother = 0;
    drive(1'b1, 2'd1, 8'h33, 3'd0, 2'd0);
    tick();
    drive(1'b0, 2'd0, 8'h00, 3'd0, 2'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL lda cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (Ld_A) nld++;
      if (Ld_B || Shift_En) nother++;
    end
    checks++;
    if (nld !== 1 || nother !== 0 || D !== 8'h33) begin
      errors++; $display("FAIL lda_pulse: got ld_a=%0d other=%0d D=%h want 1 0 33", nld, nother, D);
    end
  endtask

  task automatic test_exec();
    int nsh = 0, done_at = -1;
    drive(1'b1, 2'd3, 8'hC3, 3'b010, 2'b01);
    tick();
    drive(1'b0, 2'd0, 8'h00, 3'd0, 2'd0);
    for (int c = 0; c < 14; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL exec cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (Shift_En) nsh++;
      if (done && done_at < 0) done_at = c;
    end
    checks++;
    if (nsh !== WIDTH || done_at !== WIDTH || F_S !== 3'd2 || R_S !== 2'd1) begin
      errors++; $display("FAIL exec_shape: got shifts=%0d done_at=%0d F=%0d R=%0d want 8 8 2 1", nsh, done_at, F_S, R_S);
    end
  endtask

  task automatic test_back_to_back();
    int peak = 0, ndone = 0, nsh = 0, first_a = -1, first_b = -1, first_s = -1;
    logic [1:0] ops [3];
    logic [7:0] dat [3];
    ops = '{2'd1, 2'd2, 2'd3};
    dat = '{8'hAA, 8'h55, 8'h0F};
    for (int c = 0; c < 26; c++) begin
      if (c < 3) drive(1'b1, ops[c], dat[c], 3'($urandom_range(7)), 2'($urandom_range(3)));
      else       drive(1'b0, 2'd0, 8'h00, 3'd0, 2'd0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (done) ndone++;
      if (Shift_En) nsh++;
      if (Ld_A && first_a < 0) first_a = c;
      if (Ld_B && first_b < 0) first_b = c;
      if (Shift_En && first_s < 0) first_s = c;
    end
    checks++;
    if (peak !== 2 || ndone !== 3 || nsh !== WIDTH || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_summary: got peak=%0d done=%0d shifts=%0d busy=%b want 2 3 8 0", peak, ndone, nsh, busy);
    end
    checks++;
    if (!(first_a >= 0 && first_a < first_b && first_b < first_s)) begin
      errors++; $display("FAIL b2b_order: got a=%0d b=%0d s=%0d want increasing", first_a, first_b, first_s);
    end
  endtask

  task automatic test_fill();
    int k = 0, ndone = 0;
    bit saw_block = 1'b0;
    logic [1:0] ops [5];
    ops = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
    drive(1'b1, 2'd3, 8'h81, 3'd5, 2'd2);
    tick();
    for (int c = 0; c < 100; c++) begin
      if (k < 5) drive(1'b1, ops[k], 8'(8'h10 + k), 3'(k), 2'(k));
      else       drive(1'b0, 2'd0, 8'h00, 3'd0, 2'd0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL fill cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (fifo_count === 3'd4 && cmd_ready === 1'b0) saw_block = 1'b1;
      if (done) ndone++;
      if (m_pushed && k < 5) k++;
    end
    checks++;
    if (k !== 5 || ndone !== 6 || saw_block !== 1'b1) begin
      errors++; $display("FAIL fill_summary: got pushed=%0d done=%0d blocked=%b want 5 6 1", k, ndone, saw_block);
    end
  endtask

  task automatic test_abort();
    int ndone = 0;
    drive(1'b1, 2'd3, 8'h5A, 3'd6, 2'd3); tick();
    drive(1'b1, 2'd1, 8'h11, 3'd0, 2'd0); tick();
    drive(1'b1, 2'd2, 8'h22, 3'd0, 2'd0); tick();
    drive(1'b0, 2'd0, 8'h00, 3'd0, 2'd0); tick(); tick();
    drive(1'b1, 2'd1, 8'h77, 3'd0, 2'd0);
    abort = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || Shift_En !== 1'b1 || fifo_count !== 3'd2) begin
      errors++; $display("FAIL abort_pre: got ready=%b shift=%b count=%0d want 0 1 2", cmd_ready, Shift_En, fifo_count);
    end
    tick();
    checks++;
    if (Shift_En !== 1'b0 || fifo_count !== 3'd0 || done !== 1'b0 || busy !== 1'b0 || D !== 8'h5A) begin
      errors++; $display("FAIL abort_post: got shift=%b count=%0d done=%b busy=%b D=%h want 0 0 0 0 5a",
                         Shift_En, fifo_count, done, busy, D);
    end
    abort = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 3'd0, 2'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL abort cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL abort_nodone: got %0d done pulses want 0", ndone);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 640; c++) begin
      if (c < 600) begin
        drive(1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom),
              3'($urandom_range(7)), 2'($urandom_range(3)));
        abort = ($urandom_range(39) == 0);
      end else begin
        drive(1'b0, 2'd0, 8'h00, 3'd0, 2'd0);
        abort = 1'b0;
      end
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int nsh = 0;
    drive(1'b1, 2'd3, 8'hA5, 3'd5, 2'd2); tick();
    drive(1'b0, 2'd0, 8'h00, 3'd0, 2'd0); tick(); tick();
    #1;
    Reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (Shift_En !== 1'b0 || done !== 1'b0 || D !== 8'h00 || F_S !== 3'd0 || R_S !== 2'd0) begin
      errors++; $display("FAIL rst_async: got shift=%b done=%b D=%h F=%0d R=%0d want all 0", Shift_En, done, D, F_S, R_S);
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rst_release cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (Shift_En) nsh++;
    end
    checks++;
    if (nsh !== 0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_no_resume: got shifts=%0d ready=%b want 0 1", nsh, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_exec();
    test_back_to_back();
    test_fill();
    test_abort();
    test_random();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
